// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the memory-port arbiter
package arb_pkg;

  localparam int NUM_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational 8-way round-robin / fixed-priority winner picker
module rr_pick8 (
  input  logic [7:0] pend,
  input  logic [2:0] ptr,
  input  logic       fixed,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] base;
  logic [7:0] rot;
  logic [2:0] first;

  // Fixed priority is round robin with the search origin pinned to requester 0.
  assign base = fixed ? 3'd0 : ptr;

  always_comb begin
    rot   = 8'({pend, pend} >> base);
    first = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) first = 3'(i);
    end
  end

  assign valid = |pend;
  assign idx   = first + base;

endmodule

// File: rtl/mem_port_arbiter8.sv
// rtl/mem_port_arbiter8.sv - arbitrates one physical memory port among 8 requesters
module mem_port_arbiter8
  import arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic               mem_resp,
  output logic [2:0]         sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               mem_read,
  output logic               mem_write,
  output logic [NUM_REQ-1:0] req_resp,
  output logic               busy
);

  arb_state_t         state, state_nxt;
  mem_op_t            op;
  logic [2:0]         ptr;
  logic [1:0]         rel_cnt;
  logic [NUM_REQ-1:0] pend;
  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic               rel_done;

  assign pend     = req_read | req_write;
  assign rel_done = (rel_cnt == 2'(RELEASE_CYCLES - 1));

  rr_pick8 u_pick (
    .pend  (pend),
    .ptr   (ptr),
    .fixed (FIXED_PRIORITY != 0),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (mem_resp)   state_nxt = RELEASE;
      RELEASE: if (rel_done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 3'd0;
      sel     <= 3'd0;
      grant   <= '0;
      op      <= OP_READ;
      rel_cnt <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            sel   <= pick_idx;
            grant <= 8'd1 << pick_idx;
            op    <= req_read[pick_idx] ? OP_READ : OP_WRITE;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            grant   <= '0;
            rel_cnt <= 2'd0;
            if (FIXED_PRIORITY == 0) ptr <= sel + 3'd1;
          end
        end
        RELEASE: rel_cnt <= rel_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Strobes decode from flops only, so they are stable for all of BUSY.
  assign mem_read  = (state == BUSY) && (op == OP_READ);
  assign mem_write = (state == BUSY) && (op == OP_WRITE);
  assign req_resp  = (state == BUSY && mem_resp) ? grant : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter8.sv
// tb/tb_mem_port_arbiter8.sv - self-checking bench for mem_port_arbiter8
module tb_mem_port_arbiter8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_read, req_write, req_resp, grant;
  logic       mem_resp, mem_read, mem_write, busy;
  logic [2:0] sel;

  logic [7:0] f_req_read, f_req_write, f_req_resp, f_grant;
  logic       f_mem_resp, f_mem_read, f_mem_write, f_busy;
  logic [2:0] f_sel;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] rd;
    logic [7:0] wr;
    logic [2:0] sel;
    logic       is_rd;
  } vec_t;
  vec_t vecs[10];

  mem_port_arbiter8 #(.FIXED_PRIORITY(0), .RELEASE_CYCLES(1)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .mem_resp(mem_resp), .sel(sel), .grant(grant), .mem_read(mem_read),
    .mem_write(mem_write), .req_resp(req_resp), .busy(busy)
  );

  mem_port_arbiter8 #(.FIXED_PRIORITY(1), .RELEASE_CYCLES(2)) u_fix (
    .clk(clk), .rst(rst), .req_read(f_req_read), .req_write(f_req_write),
    .mem_resp(f_mem_resp), .sel(f_sel), .grant(f_grant), .mem_read(f_mem_read),
    .mem_write(f_mem_write), .req_resp(f_req_resp), .busy(f_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
      chk("inv_strobes", 32'(mem_read && mem_write), 32'd0);
      chk("inv_resp", 32'((req_resp != 8'd0) && !(busy && mem_resp)), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic run_txn(input vec_t v);
    logic [7:0] eg;
    eg = 8'h01 << v.sel;
    req_read  = v.rd;
    req_write = v.wr;
    exp_q.push_back(eg);
    tick();
    chk("txn_grant", 32'(grant), 32'(eg));
    chk("txn_sel", 32'(sel), 32'(v.sel));
    chk("txn_mem_read", 32'(mem_read), 32'(v.is_rd));
    chk("txn_mem_write", 32'(mem_write), 32'(!v.is_rd));
    // winner and everyone else withdraw: transaction must continue
    req_read  = 8'h00;
    req_write = 8'h00;
    tick();
    tick();
    chk("hold_grant", 32'(grant), 32'(eg));
    chk("hold_strobes", 32'({mem_read, mem_write}), 32'({v.is_rd, !v.is_rd}));
    chk("hold_no_resp", 32'(req_resp), 32'd0);
    mem_resp = 1'b1;
    #1;
    chk("txn_req_resp", 32'(req_resp), 32'(exp_q.pop_front()));
    tick();
    chk("rel_grant", 32'(grant), 32'd0);
    chk("rel_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_resp_ignored", 32'(req_resp), 32'd0);
    mem_resp = 1'b0;
    tick();
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] e;
    bit         ok;
    int         lat;

    vecs[0] = '{8'h04, 8'h00, 3'd2, 1'b1};
    vecs[1] = '{8'h08, 8'h08, 3'd3, 1'b1};
    vecs[2] = '{8'h00, 8'h20, 3'd5, 1'b0};
    vecs[3] = '{8'h00, 8'h41, 3'd6, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 3'd0, 1'b0};
    vecs[5] = '{8'h81, 8'h00, 3'd7, 1'b1};
    vecs[6] = '{8'h03, 8'h00, 3'd0, 1'b1};
    vecs[7] = '{8'h03, 8'h00, 3'd1, 1'b1};
    vecs[8] = '{8'h10, 8'h02, 3'd4, 1'b1};
    vecs[9] = '{8'h00, 8'h12, 3'd1, 1'b0};

    rst = 1'b1;
    req_read = 8'hFF; req_write = 8'h00; mem_resp = 1'b0;
    f_req_read = 8'h00; f_req_write = 8'h00; f_mem_resp = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_outputs", 32'({sel, grant, mem_read, mem_write, req_resp, busy}), 32'd0);
    end
    rst = 1'b0;
    req_read = 8'h00;
    #1;
    chk("post_rst_outputs", 32'({sel, grant, mem_read, mem_write, req_resp, busy}), 32'd0);
    tick();
    chk("post_rst_idle", 32'({grant, busy}), 32'd0);

    mem_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", 32'(req_resp), 32'd0);
    tick();
    chk("idle_resp_no_state", 32'({grant, busy}), 32'd0);
    mem_resp = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // full-load sweep from ptr=0: 0..7 then wrap to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) exp_q.push_back(8'h01 << (k % 8));
    req_read = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      ok = 1'b0;
      lat = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        lat++;
        if (grant != 8'h00) begin
          ok = 1'b1;
          break;
        end
      end
      chk("rr_grant_seen", 32'(ok), 32'd1);
      if (!ok) break;
      e = exp_q.pop_front();
      chk("rr_order", 32'(grant), 32'(e));
      chk("rr_latency", 32'(lat), (n == 0) ? 32'd1 : 32'd2);
      if (n == 1) req_read[0] = 1'b1;
      repeat (3) tick();
      mem_resp = 1'b1;
      #1;
      chk("rr_resp", 32'(req_resp), 32'(e));
      tick();
      mem_resp = 1'b0;
      req_read = req_read & ~e;
    end
    req_read = 8'h00;
    tick();
    tick();

    // reset during BUSY, then a stale response
    req_read = 8'h10;
    tick();
    chk("busy_before_rst", 32'({grant, busy}), 32'({8'h10, 1'b1}));
    rst = 1'b1;
    req_read = 8'h00;
    tick();
    rst = 1'b0;
    chk("rst_busy_outputs", 32'({grant, mem_read, mem_write, busy}), 32'd0);
    mem_resp = 1'b1;
    #1;
    chk("late_resp_ignored", 32'(req_resp), 32'd0);
    tick();
    mem_resp = 1'b0;
    chk("late_resp_idle", 32'(busy), 32'd0);

    // fixed priority with a two-cycle release
    f_req_read = 8'hFF;
    tick();
    for (int t = 0; t < 3; t++) begin
      chk("fix_grant", 32'(f_grant), 32'h01);
      chk("fix_sel", 32'(f_sel), 32'd0);
      chk("fix_strobes", 32'({f_mem_read, f_mem_write}), 32'b10);
      tick();
      f_mem_resp = 1'b1;
      #1;
      chk("fix_resp", 32'(f_req_resp), 32'h01);
      tick();
      f_mem_resp = 1'b0;
      chk("fix_rel1", 32'({f_grant, f_busy}), 32'd1);
      tick();
      chk("fix_rel2", 32'({f_grant, f_busy}), 32'd1);
      tick();
      chk("fix_idle", 32'({f_grant, f_busy}), 32'd0);
      tick();
    end
    f_req_read = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
